com_uart_trans_ctrl: RTL and testbench

UART transmit frame controller. Pops bytes from the TX FIFO, serialises each as start / data (LSB first) / optional parity / 1 or 2 stop bits, and advances one bit per `baud_tick` from the TX baud timer. It drives the `ctrl_idle_state` and `ctrl_stop_state` status lines the timer uses to gate and realign itself. It sits between the TX FIFO and the pad.

---
 rtl/com_uart_pkg.sv | 27 ++
 rtl/com_uart_trans_ctrl.sv | 159 +++++++++++++++
 tb/tb_com_uart_trans_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/com_uart_pkg.sv
// Shared definitions for the UART transmit path.
//   tx_state_t  : frame controller state encoding
//   PARITY_*    : parity_mode encodings (2'b11 is treated as no parity)
//   STOP_*      : stop_bits encodings
//   has_parity  : true when a parity mode inserts a parity bit
package com_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam logic [1:0] PARITY_NONE = 2'd0;
    localparam logic [1:0] PARITY_ODD  = 2'd1;
    localparam logic [1:0] PARITY_EVEN = 2'd2;

    localparam logic STOP_ONE = 1'b0;
    localparam logic STOP_TWO = 1'b1;

    function automatic logic has_parity(input logic [1:0] mode);
        return (mode == PARITY_ODD) || (mode == PARITY_EVEN);
    endfunction

endpackage

// File: rtl/com_uart_trans_ctrl.sv
// UART transmit frame controller.
// Pops words from a show-ahead TX FIFO and serialises each one as
// start / data (LSB first) / optional parity / 1 or 2 stop bits, advancing
// one bit per baud_tick.
// Ports:
//   clk, rst          : system clock, asynchronous active-high reset
//   tx_en             : allows new frames to start
//   parity_mode       : 00 none, 01 odd, 10 even, 11 none
//   stop_bits         : 0 one stop bit, 1 two stop bits
//   baud_tick         : one-cycle bit-period strobe from the baud timer
//   FIFO_empty        : TX FIFO empty flag
//   fifo_data         : FIFO head word (valid when !FIFO_empty)
//   fifo_rd           : one-cycle pop strobe
//   TX                : serial output, idle high
//   ctrl_idle_state   : high in IDLE
//   ctrl_stop_state   : high in STOP
//   tx_busy           : high outside IDLE
//   frame_done        : one-cycle pulse when a frame completes
module com_uart_trans_ctrl
    import com_uart_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int BIT_CNT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_en,
    input  logic [1:0]            parity_mode,
    input  logic                  stop_bits,
    input  logic                  baud_tick,
    input  logic                  FIFO_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd,
    output logic                  TX,
    output logic                  ctrl_idle_state,
    output logic                  ctrl_stop_state,
    output logic                  tx_busy,
    output logic                  frame_done
);

    localparam logic [BIT_CNT_WIDTH-1:0] LAST_BIT = BIT_CNT_WIDTH'(DATA_WIDTH - 1);

    tx_state_t               state;
    tx_state_t               state_nxt;
    logic [DATA_WIDTH-1:0]   shift_reg;
    logic [DATA_WIDTH-1:0]   data_cap;
    logic [BIT_CNT_WIDTH-1:0] bit_cnt;
    logic                    stop_cnt;
    logic [1:0]              cfg_parity;
    logic                    cfg_stop;
    logic                    can_load;
    logic                    load;
    logic                    last_stop;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; load/last_stop mark the two load decision points
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        last_stop = 1'b0;
        can_load  = tx_en & ~FIFO_empty;
        case (state)
            ST_IDLE: begin
                if (can_load) begin
                    load      = 1'b1;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (baud_tick) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_tick && (bit_cnt == LAST_BIT)) begin
                    state_nxt = has_parity(cfg_parity) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (baud_tick) begin
                    state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                // stop_cnt is set after the first of two stop ticks
                if (baud_tick && ((cfg_stop == STOP_ONE) || stop_cnt)) begin
                    last_stop = 1'b1;
                    if (can_load) begin
                        load      = 1'b1;
                        state_nxt = ST_START;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: shift register, captured word, counters, frame config, strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg  <= '0;
            data_cap   <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            cfg_parity <= PARITY_NONE;
            cfg_stop   <= STOP_ONE;
            fifo_rd    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            fifo_rd    <= load;
            frame_done <= last_stop;

            if (load) begin
                shift_reg  <= fifo_data;
                data_cap   <= fifo_data;
                cfg_parity <= parity_mode;
                cfg_stop   <= stop_bits;
            end else if ((state == ST_DATA) && baud_tick) begin
                shift_reg <= shift_reg >> 1;
            end

            if ((state == ST_START) && baud_tick) begin
                bit_cnt <= '0;
            end else if ((state == ST_DATA) && baud_tick) begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            // Cleared on the final stop tick so the next STOP entry starts at 0
            if ((state == ST_STOP) && baud_tick) begin
                stop_cnt <= ~last_stop;
            end
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        TX              = 1'b1;
        ctrl_idle_state = (state == ST_IDLE);
        ctrl_stop_state = (state == ST_STOP);
        tx_busy         = (state != ST_IDLE);
        case (state)
            ST_START:  TX = 1'b0;
            ST_DATA:   TX = shift_reg[0];
            ST_PARITY: TX = (cfg_parity == PARITY_EVEN) ? ^data_cap : ~^data_cap;
            default:   TX = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_com_uart_trans_ctrl.sv
// Self-checking bench for com_uart_trans_ctrl.
// A frame-level reference model (a list of line bits per frame) runs on each
// rising edge and queues the expected outputs for the following cycle; a
// monitor on the falling edge pops and compares them and services the FIFO.
module tb_com_uart_trans_ctrl;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tx_en = 1'b0;
    logic [1:0]    parity_mode = 2'd0;
    logic          stop_bits = 1'b0;
    logic          baud_tick = 1'b0;
    logic          FIFO_empty = 1'b1;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_rd, TX, ctrl_idle_state, ctrl_stop_state, tx_busy, frame_done;

    com_uart_trans_ctrl #(.DATA_WIDTH(DW)) dut (
        .clk             (clk),
        .rst             (rst),
        .tx_en           (tx_en),
        .parity_mode     (parity_mode),
        .stop_bits       (stop_bits),
        .baud_tick       (baud_tick),
        .FIFO_empty      (FIFO_empty),
        .fifo_data       (fifo_data),
        .fifo_rd         (fifo_rd),
        .TX              (TX),
        .ctrl_idle_state (ctrl_idle_state),
        .ctrl_stop_state (ctrl_stop_state),
        .tx_busy         (tx_busy),
        .frame_done      (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic tx;
        logic idle;
        logic stop;
        logic busy;
        logic rd;
        logic done;
    } obs_t;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- FIFO model ----------------
    logic [DW-1:0] fq[$];

    task automatic fifo_refresh();
        FIFO_empty = (fq.size() == 0);
        fifo_data  = (fq.size() == 0) ? '0 : fq[0];
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        fq.push_back(w);
        fifo_refresh();
    endtask

    // ---------------- baud tick generator ----------------
    int tick_period = 16;
    int tick_cnt    = 0;
    always @(negedge clk) begin
        if (tick_cnt >= tick_period - 1) begin
            baud_tick = 1'b1;
            tick_cnt  = 0;
        end else begin
            baud_tick = 1'b0;
            tick_cnt++;
        end
    end

    // ---------------- reference model ----------------
    bit   m_busy = 1'b0;
    bit   m_bits[$];
    int   m_nstop = 1;
    bit   m_rd, m_done;
    obs_t exp_q[$];

    // Builds the full line sequence of one frame from the word and current config
    task automatic m_load(input logic [DW-1:0] w);
        int ones;
        ones = $countones(w);
        m_bits.delete();
        m_bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) m_bits.push_back(w[i]);
        if (parity_mode == 2'd2) m_bits.push_back(bit'(ones % 2));
        if (parity_mode == 2'd1) m_bits.push_back(bit'((ones + 1) % 2));
        m_nstop = stop_bits ? 2 : 1;
        for (int i = 0; i < m_nstop; i++) m_bits.push_back(1'b1);
        m_busy = 1'b1;
        m_rd   = 1'b1;
    endtask

    always @(posedge clk) begin
        obs_t e;
        m_rd   = 1'b0;
        m_done = 1'b0;
        if (rst) begin
            m_busy = 1'b0;
            m_bits.delete();
        end else if (!m_busy) begin
            if (tx_en && fq.size() > 0) m_load(fq[0]);
        end else if (baud_tick) begin
            void'(m_bits.pop_front());
            if (m_bits.size() == 0) begin
                m_done = 1'b1;
                if (tx_en && fq.size() > 0) m_load(fq[0]);
                else m_busy = 1'b0;
            end
        end
        e.tx   = m_busy ? m_bits[0] : 1'b1;
        e.idle = !m_busy;
        e.stop = m_busy && (m_bits.size() <= m_nstop);
        e.busy = m_busy;
        e.rd   = m_rd;
        e.done = m_done;
        exp_q.push_back(e);
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        obs_t a, e;
        a = {TX, ctrl_idle_state, ctrl_stop_state, tx_busy, fifo_rd, frame_done};
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (a !== e) begin
                n_err++;
                $display("FAIL outputs @%0t: {tx,idle,stop,busy,rd,done} got=%b required=%b",
                         $time, a, e);
            end
        end
        if (fifo_rd === 1'b1) begin
            if (fq.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rd_when_empty @%0t: fifo_rd=1 required=0", $time);
            end else begin
                void'(fq.pop_front());
            end
        end
        fifo_refresh();
    end

    // ---------------- stimulus ----------------
    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (!(!m_busy && fq.size() == 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout_%s: idle after %0d cycles, required within %0d", name, n, budget);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic run_frame(input string name, input logic [DW-1:0] w,
                             input logic [1:0] pm, input logic sb);
        parity_mode = pm;
        stop_bits   = sb;
        push_word(w);
        tx_en = 1'b1;
        wait_idle(name, 400);
    endtask

    initial begin
        fifo_refresh();
        #1;
        n_vec++;
        if ({TX, ctrl_idle_state, ctrl_stop_state, tx_busy, fifo_rd, frame_done} !== 6'b110000) begin
            n_err++;
            $display("FAIL reset_state: got=%b required=110000",
                     {TX, ctrl_idle_state, ctrl_stop_state, tx_busy, fifo_rd, frame_done});
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Directed frames, tick every 16 cycles
        tick_period = 16;
        run_frame("x55", 8'h55, 2'd0, 1'b0);
        run_frame("x07_even", 8'h07, 2'd2, 1'b0);
        run_frame("x07_odd", 8'h07, 2'd1, 1'b0);
        run_frame("mode11", 8'hC3, 2'd3, 1'b0);
        run_frame("two_stop", 8'h81, 2'd0, 1'b1);

        // Back-to-back words
        tx_en = 1'b0;
        push_word(8'hA5);
        push_word(8'h3C);
        @(negedge clk);
        tx_en = 1'b1;
        wait_idle("b2b", 800);

        // tx_en low holds a non-empty FIFO
        tx_en = 1'b0;
        push_word(8'h5A);
        repeat (40) @(negedge clk);
        tx_en = 1'b1;
        wait_idle("tx_en", 400);

        // Reset during data bit 3, then a clean frame
        tick_period = 8;
        parity_mode = 2'd0;
        stop_bits   = 1'b0;
        push_word(8'h96);
        begin
            int n;
            n = 0;
            while (!(m_busy && m_bits.size() == 6) && n < 400) begin
                @(negedge clk);
                n++;
            end
            if (n >= 400) begin
                n_vec++;
                n_err++;
                $display("FAIL timeout_bit3: reached after %0d cycles, required within 400", n);
            end
        end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({TX, ctrl_idle_state, tx_busy} !== 3'b110) begin
            n_err++;
            $display("FAIL async_reset: {tx,idle,busy} got=%b required=110",
                     {TX, ctrl_idle_state, tx_busy});
        end
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        run_frame("after_rst", 8'h3C, 2'd2, 1'b1);

        // Randomized traffic with mid-frame config/enable churn
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 99) < 20 && fq.size() < 4) push_word(DW'($urandom));
            parity_mode = 2'($urandom_range(0, 3));
            stop_bits   = 1'($urandom_range(0, 1));
            tx_en       = ($urandom_range(0, 99) < 90);
            if ($urandom_range(0, 299) == 0) tick_period = $urandom_range(1, 12);
        end
        tx_en = 1'b1;
        wait_idle("random", 2000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
